riscy_l2_cache_nway: RTL and testbench
======================================

// Module: riscy_l2_cache_nway
// PURPOSE
//  Parametrised N-way set-associative, write-back, write-allocate L2 cache: controller FSM and datapath in one block.
//  Sits between the L1 arbiter (256-bit line bus, byte-enabled writes) and physical memory.
//  Generalises the fixed 4-way L2 to any power-of-two way count with tree pseudo-LRU replacement.
// PARAMETERS
//  s_offset  5                        byte-offset bits; line = 2**s_offset bytes
//  s_index   3                        index bits; num_sets = 2**s_index
//  num_ways  4                        associativity; power of two, >= 2
//  s_tag     32-s_offset-s_index      tag width (derived)
//  s_line    8*2**s_offset            line width in bits (derived)
// PORTS
//  clk              in   1           clock, rising edge
//  rst              in   1           asynchronous active-high reset
//  mem_read         in   1           upstream read request; held until mem_resp
//  mem_write        in   1           upstream write request; held until mem_resp
//  mem_address      in   32          upstream byte address
//  mem_wdata        in   s_line      upstream write line
//  mem_byte_enable  in   s_line/8    per-byte write enable
//  mem_rdata        out  s_line      read line; valid only while mem_resp=1
//  mem_resp         out  1           one-cycle completion pulse
//  pmem_read        out  1           memory line read; held until pmem_resp
//  pmem_write       out  1           memory line write; held until pmem_resp
//  pmem_address     out  32          line-aligned memory address
//  pmem_wdata       out  s_line      victim line being written back
//  pmem_rdata       in   s_line      fill line; sampled when pmem_resp=1
//  pmem_resp        in   1           memory completion pulse
// BEHAVIOUR
//  - Reset (async): FSM->IDLE; all valid, dirty and PLRU bits cleared.
//    mem_resp=0, pmem_read=0, pmem_write=0 immediately; tag/data contents not reset.
//  - States: IDLE, CHECK, WRITEBACK, FILL.
//    IDLE: arrays read at index mem_address[s_offset+:s_index]; on mem_read|mem_write -> CHECK.
//    CHECK: hit[w] = valid[w] & tag[w]==mem_address[31-:s_tag]; at most one hit (one-hot).
//      Hit: mem_resp=1 this cycle; PLRU updated with hit way. On write, bytes with byte_enable=1 are written and dirty set. -> IDLE.
//      Miss: victim = lowest-index invalid way, else the PLRU victim. Victim valid & dirty -> WRITEBACK, else -> FILL.
//    WRITEBACK: pmem_write=1; pmem_address={victim tag,index,0}; pmem_wdata=victim line.
//      On pmem_resp -> FILL.
//    FILL: pmem_read=1; pmem_address={mem_address[31:s_offset],0}.
//      On pmem_resp: victim data<=pmem_rdata, tag loaded, valid set, dirty cleared -> CHECK (re-read, guaranteed hit).
//  - Latency: hit = mem_resp 2 cycles after request rises (IDLE, CHECK). Miss adds the memory transactions plus one CHECK.
//  - pmem_address/pmem_wdata stable while pmem_read/pmem_write high; never both high.
//    In IDLE/CHECK, pmem_address = {mem_address[31:s_offset],0}.
//  - mem_read & mem_write both high: treated as write.
//    Request dropped before mem_resp: illegal, not checked.
//  - PLRU: num_ways-1 bits per set, binary tree.
//    Victim walk: bit=0 go lower half, bit=1 go upper half.
//    On access: each node on the path is set to point away from the accessed way.
//  - pmem_resp outside WRITEBACK/FILL is ignored.
//  - Reset mid-WRITEBACK/FILL abandons the transaction; the partial line is not installed.
// STRUCTURE
//  - riscy_l2_pkg: state enum (IDLE, CHECK, WRITEBACK, FILL) and line/tag typedefs.
//  - Sub-module riscy_l2_plru_array #(num_ways, num_sets):
//    async-reset PLRU storage, update port (index, way) and victim output.
//  - Data/tag/valid/dirty arrays instantiated per way via generate.
//    Way select, hit and victim logic are for-loops over num_ways; no hard-coded way cases.
// TESTING (num_ways=4, s_index=3, s_offset=5)
//  1. Reset, read 0x0000_1000:
//     -> pmem_read at 0x0000_1000; pmem_rdata=A with pmem_resp -> mem_resp, mem_rdata=A.
//     Re-read -> mem_resp exactly 2 cycles after request, no pmem activity.
//  2. Write 0x1000, byte_enable=0x0000_000F, wdata[31:0]=0xDEADBEEF -> hit, no pmem.
//     Read 0x1000 -> A with bytes 0..3 = EF,BE,AD,DE.
//  3. Read 0x2000, 0x3000, 0x4000, then 0x2000, 0x3000, 0x4000 (set 0 full, way0 LRU);
//     read 0x5000 -> pmem_write 0x1000 with the line from test 2, then pmem_read 0x5000.
//  4. Repeat with all lines clean -> eviction issues pmem_read only, no pmem_write.
//  5. Assert rst while pmem_read=1 -> pmem_read=0 same cycle;
//     after release, read 0x1000 -> misses (valid cleared).
//  6. pmem_resp delayed 10 cycles in WRITEBACK and FILL -> pmem_address/pmem_wdata stable, mem_resp stays 0.
//  7. Simultaneous mem_read & mem_write -> behaves as write.

Source files
------------

// File: rtl/riscy_l2_pkg.sv
// Shared types for the N-way L2 cache: controller state encoding, address type and
// line/tag types for the default geometry (32-byte lines, 8 sets). A helper
// returns the line-aligned form of a byte address.
package riscy_l2_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DefOffset = 5;
  localparam int unsigned DefIndex  = 3;
  localparam int unsigned DefLine   = 8 * (2 ** DefOffset);
  localparam int unsigned DefTag    = AddrWidth - DefOffset - DefIndex;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StWriteback,
    StFill
  } l2_state_e;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DefLine-1:0]   line_t;
  typedef logic [DefTag-1:0]    tag_t;

  // Clears the byte-offset bits of an address.
  function automatic addr_t line_base(input addr_t a, input int unsigned off);
    return a & ~((addr_t'(1) << off) - addr_t'(1));
  endfunction

endpackage

// File: rtl/riscy_l2_cache_nway_if.sv
// Bus bundle between the L1 arbiter, the L2 cache and physical memory.
//   mem_*  : upstream line request (read/write, byte enables) and its response pulse
//   pmem_* : downstream line read/write towards memory and its response pulse
// Modports: slave = the cache itself; master = the environment (arbiter + memory).
interface riscy_l2_cache_nway_if #(
  parameter int unsigned s_line = 256
) ();

  logic                  mem_read;
  logic                  mem_write;
  logic [31:0]           mem_address;
  logic [s_line-1:0]     mem_wdata;
  logic [s_line/8-1:0]   mem_byte_enable;
  logic [s_line-1:0]     mem_rdata;
  logic                  mem_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [31:0]           pmem_address;
  logic [s_line-1:0]     pmem_wdata;
  logic [s_line-1:0]     pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/riscy_l2_plru_array.sv
// Tree pseudo-LRU state for every set of an N-way cache.
//   clk, rst   : clock, asynchronous active-high reset (all tree bits cleared)
//   index_i    : set being looked up / updated
//   upd_en_i   : record an access to upd_way_i in set index_i
//   upd_way_i  : accessed way
//   victim_o   : way selected by walking the tree of set index_i
// Tree nodes are stored heap-ordered: node n has children 2n+1 (lower) and 2n+2 (upper).
// A node bit of 0 points at its lower half, 1 at its upper half.
module riscy_l2_plru_array #(
  parameter int unsigned num_ways = 4,
  parameter int unsigned num_sets = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(num_sets)-1:0] index_i,
  input  logic                        upd_en_i,
  input  logic [$clog2(num_ways)-1:0] upd_way_i,
  output logic [$clog2(num_ways)-1:0] victim_o
);

  localparam int unsigned WayW = $clog2(num_ways);

  logic [num_ways-2:0] tree_q [num_sets];
  logic [num_ways-2:0] tree_d [num_sets];

  // Every node on the accessed way's path is turned to point away from it.
  always_comb begin
    logic [num_ways-2:0] row_upd;
    int unsigned         node;
    tree_d  = tree_q;
    row_upd = tree_q[index_i];
    node    = 0;
    for (int lvl = 0; lvl < WayW; lvl++) begin
      row_upd[node] = ~upd_way_i[WayW-1-lvl];
      node          = 2 * node + 1 + (upd_way_i[WayW-1-lvl] ? 1 : 0);
    end
    if (upd_en_i) begin
      tree_d[index_i] = row_upd;
    end
  end

  // Victim walk: the bits collected from root to leaf form the way number, MSB first.
  always_comb begin
    logic [num_ways-2:0] row_rd;
    int unsigned         node;
    row_rd   = tree_q[index_i];
    victim_o = '0;
    node     = 0;
    for (int lvl = 0; lvl < WayW; lvl++) begin
      victim_o[WayW-1-lvl] = row_rd[node];
      node                 = 2 * node + 1 + (row_rd[node] ? 1 : 0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < num_sets; s++) begin
        tree_q[s] <= '0;
      end
    end else begin
      tree_q <= tree_d;
    end
  end

endmodule

// File: rtl/riscy_l2_cache_nway.sv
// N-way set-associative, write-back, write-allocate L2 cache (controller + datapath).
//   clk, rst : clock, asynchronous active-high reset (FSM idle, valid/dirty/PLRU cleared)
//   bus      : slave side of riscy_l2_cache_nway_if
//     mem_*  : upstream requests held until the one-cycle mem_resp
//     pmem_* : line reads (fills) and writes (victim write-backs) to memory
// Arrays are read combinationally at the index of the held request address, so the
// IDLE cycle only launches the lookup and CHECK resolves hit/miss.
module riscy_l2_cache_nway
  import riscy_l2_pkg::*;
#(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 3,
  parameter int unsigned num_ways = 4
) (
  input logic                  clk,
  input logic                  rst,
  riscy_l2_cache_nway_if.slave bus
);

  localparam int unsigned s_tag    = AddrWidth - s_offset - s_index;
  localparam int unsigned s_line   = 8 * (2 ** s_offset);
  localparam int unsigned s_mask   = s_line / 8;
  localparam int unsigned num_sets = 2 ** s_index;
  localparam int unsigned WayW     = $clog2(num_ways);

  typedef logic [s_line-1:0] cline_t;
  typedef logic [s_tag-1:0]  ctag_t;

  l2_state_e           state_q, state_d;
  logic [WayW-1:0]     victim_q, victim_d;
  logic [num_ways-1:0] valid_q [num_sets];
  logic [num_ways-1:0] valid_d [num_sets];
  logic [num_ways-1:0] dirty_q [num_sets];
  logic [num_ways-1:0] dirty_d [num_sets];

  logic [s_index-1:0]  idx;
  ctag_t               addr_tag;
  logic                req;
  logic                is_write;

  cline_t              rd_data [num_ways];
  ctag_t               rd_tag  [num_ways];
  logic [num_ways-1:0] cur_valid, cur_dirty, hit;
  logic                any_hit;
  logic [WayW-1:0]     hit_way, plru_victim, victim_sel;
  cline_t              hit_data;

  logic [num_ways-1:0] data_we, tag_we;
  cline_t              wline;
  logic [s_mask-1:0]   wbe;
  logic                plru_upd;

  logic                resp, pread, pwrite;
  addr_t               paddr;

  assign idx      = bus.mem_address[s_offset +: s_index];
  assign addr_tag = bus.mem_address[31 -: s_tag];
  assign req      = bus.mem_read | bus.mem_write;
  assign is_write = bus.mem_write;  // read+write together is a write

  // Per-way data and tag storage; not reset, only valid bits qualify contents.
  for (genvar w = 0; w < num_ways; w++) begin : g_way
    cline_t data_q [num_sets];
    ctag_t  tag_q  [num_sets];

    always_ff @(posedge clk) begin
      if (data_we[w]) begin
        for (int b = 0; b < s_mask; b++) begin
          if (wbe[b]) begin
            data_q[idx][8*b +: 8] <= wline[8*b +: 8];
          end
        end
      end
      if (tag_we[w]) begin
        tag_q[idx] <= addr_tag;
      end
    end

    assign rd_data[w] = data_q[idx];
    assign rd_tag[w]  = tag_q[idx];
  end

  riscy_l2_plru_array #(
    .num_ways (num_ways),
    .num_sets (num_sets)
  ) u_plru (
    .clk       (clk),
    .rst       (rst),
    .index_i   (idx),
    .upd_en_i  (plru_upd),
    .upd_way_i (hit_way),
    .victim_o  (plru_victim)
  );

  // Hit detection (one-hot), hit-way encode/mux and victim choice.
  always_comb begin
    cur_valid  = valid_q[idx];
    cur_dirty  = dirty_q[idx];
    hit        = '0;
    hit_way    = '0;
    hit_data   = '0;
    for (int w = 0; w < num_ways; w++) begin
      hit[w] = cur_valid[w] && (rd_tag[w] == addr_tag);
      if (hit[w]) begin
        hit_way  = hit_way | WayW'(w);
        hit_data = hit_data | rd_data[w];
      end
    end
    // Lowest-index invalid way beats the PLRU choice; scan downwards so it wins last.
    victim_sel = plru_victim;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!cur_valid[w]) begin
        victim_sel = WayW'(w);
      end
    end
  end

  assign any_hit = |hit;

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    resp     = 1'b0;
    pread    = 1'b0;
    pwrite   = 1'b0;
    paddr    = line_base(bus.mem_address, s_offset);
    data_we  = '0;
    tag_we   = '0;
    wline    = bus.mem_wdata;
    wbe      = bus.mem_byte_enable;
    plru_upd = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (any_hit) begin
          resp     = 1'b1;
          plru_upd = 1'b1;
          if (is_write) begin
            data_we[hit_way]      = 1'b1;
            dirty_d[idx][hit_way] = 1'b1;
          end
          state_d = StIdle;
        end else begin
          victim_d = victim_sel;
          if (cur_valid[victim_sel] && cur_dirty[victim_sel]) begin
            state_d = StWriteback;
          end else begin
            state_d = StFill;
          end
        end
      end
      StWriteback: begin
        pwrite = 1'b1;
        paddr  = {rd_tag[victim_q], idx, {s_offset{1'b0}}};
        if (bus.pmem_resp) begin
          state_d = StFill;
        end
      end
      StFill: begin
        pread = 1'b1;
        if (bus.pmem_resp) begin
          data_we[victim_q]      = 1'b1;
          tag_we[victim_q]       = 1'b1;
          wline                  = bus.pmem_rdata;
          wbe                    = '1;
          valid_d[idx][victim_q] = 1'b1;
          dirty_d[idx][victim_q] = 1'b0;
          // Back to CHECK: the re-read is a guaranteed hit and completes the request.
          state_d                = StCheck;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      victim_q <= '0;
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
    end
  end

  assign bus.mem_rdata    = hit_data;
  assign bus.mem_resp     = resp;
  assign bus.pmem_read    = pread;
  assign bus.pmem_write   = pwrite;
  assign bus.pmem_address = paddr;
  assign bus.pmem_wdata   = rd_data[victim_q];

endmodule

// File: tb/tb_riscy_l2_cache_nway.sv
// Directed bench for riscy_l2_cache_nway (4 ways, 8 sets, 32-byte lines).
// A small memory model answers pmem requests after mem_delay cycles with a
// deterministic fill pattern and records every transaction it sees.
module tb_riscy_l2_cache_nway;
  import riscy_l2_pkg::*;

  localparam int unsigned SLine = DefLine;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  riscy_l2_cache_nway_if #(.s_line(SLine)) bus ();

  riscy_l2_cache_nway #(
    .s_offset (5),
    .s_index  (3),
    .num_ways (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    mem_delay;

  // Written only by the memory model.
  int    n_rd = 0, n_wr = 0, n_unstable = 0, n_resp_pmem = 0, n_both = 0;
  addr_t last_rd_addr, last_wr_addr;
  line_t last_wr_data;

  // Snapshots taken by the main sequence.
  int    s_rd, s_wr, s_unstable, s_resp_pmem;

  function automatic line_t fill_line(input addr_t a);
    line_t l;
    for (int i = 0; i < 8; i++) begin
      l[32*i +: 32] = a | addr_t'(i);
    end
    return l;
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_rd        = n_rd;
    s_wr        = n_wr;
    s_unstable  = n_unstable;
    s_resp_pmem = n_resp_pmem;
  endtask

  // Presents one request, waits (bounded) for mem_resp, then drops it.
  task automatic do_req(input logic rd, input logic wr, input addr_t addr, input line_t wdata,
                        input logic [31:0] be, output line_t rdata, output int cycles);
    logic got;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_wdata       = wdata;
    bus.mem_byte_enable = be;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 400) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.mem_resp) got = 1'b1;
    end
    check_eq("resp_seen", got, 1);
    rdata = bus.mem_rdata;
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // Memory model.
  initial begin
    logic  is_wr, aborted;
    addr_t a;
    line_t d;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.pmem_read && bus.pmem_write) n_both++;
      if (!rst && (bus.pmem_read || bus.pmem_write)) begin
        is_wr = bus.pmem_write;
        a     = bus.pmem_address;
        d     = bus.pmem_wdata;
        if (is_wr) begin
          n_wr++;
          last_wr_addr = a;
          last_wr_data = d;
        end else begin
          n_rd++;
          last_rd_addr = a;
        end
        aborted = 1'b0;
        for (int k = 1; k < mem_delay && !aborted; k++) begin
          @(posedge clk);
          #1;
          if (rst) begin
            aborted = 1'b1;
          end else begin
            if (bus.pmem_address != a || (is_wr && bus.pmem_wdata != d)) n_unstable++;
            if (bus.mem_resp) n_resp_pmem++;
            if (bus.pmem_read && bus.pmem_write) n_both++;
          end
        end
        if (!aborted) begin
          bus.pmem_resp = 1'b1;
          if (!is_wr) bus.pmem_rdata = fill_line(a);
          @(posedge clk);
          #1;
          bus.pmem_resp = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    line_t rd, w, exp2, exp7;
    int    cyc;
    addr_t seq [6];

    rst                 = 1'b1;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;
    mem_delay           = 2;
    #2;
    check_eq("rst_mem_resp", bus.mem_resp, 0);
    check_eq("rst_pmem_read", bus.pmem_read, 0);
    check_eq("rst_pmem_write", bus.pmem_write, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: cold miss fills, then a hit with no memory traffic.
    snap();
    do_req(1'b1, 1'b0, 32'h1000, '0, '0, rd, cyc);
    check_eq("t1_rdata", rd, fill_line(32'h1000));
    check_eq("t1_fill_cnt", n_rd - s_rd, 1);
    check_eq("t1_fill_addr", last_rd_addr, 32'h1000);
    check_eq("t1_no_wb", n_wr - s_wr, 0);
    snap();
    do_req(1'b1, 1'b0, 32'h1000, '0, '0, rd, cyc);
    check_eq("t1_hit_rdata", rd, fill_line(32'h1000));
    check_eq("t1_hit_lat", cyc, 1);
    check_eq("t1_hit_no_pmem", (n_rd + n_wr) - (s_rd + s_wr), 0);

    // 2: partial write hit.
    w        = '0;
    w[31:0]  = 32'hDEAD_BEEF;
    snap();
    do_req(1'b0, 1'b1, 32'h1000, w, 32'h0000_000F, rd, cyc);
    check_eq("t2_wr_lat", cyc, 1);
    check_eq("t2_wr_no_pmem", (n_rd + n_wr) - (s_rd + s_wr), 0);
    exp2       = fill_line(32'h1000);
    exp2[31:0] = 32'hDEAD_BEEF;
    do_req(1'b1, 1'b0, 32'h1000, '0, '0, rd, cyc);
    check_eq("t2_rdata", rd, exp2);

    // 3: fill set 0, make way0 LRU, evict the dirty line.
    seq = '{32'h2000, 32'h3000, 32'h4000, 32'h2000, 32'h3000, 32'h4000};
    foreach (seq[i]) do_req(1'b1, 1'b0, seq[i], '0, '0, rd, cyc);
    snap();
    do_req(1'b1, 1'b0, 32'h5000, '0, '0, rd, cyc);
    check_eq("t3_wb_cnt", n_wr - s_wr, 1);
    check_eq("t3_wb_addr", last_wr_addr, 32'h1000);
    check_eq("t3_wb_data", last_wr_data, exp2);
    check_eq("t3_fill_cnt", n_rd - s_rd, 1);
    check_eq("t3_fill_addr", last_rd_addr, 32'h5000);
    check_eq("t3_rdata", rd, fill_line(32'h5000));
    do_req(1'b1, 1'b0, 32'h2000, '0, '0, rd, cyc);
    check_eq("t3_survivor_hit", cyc, 1);

    // 4: clean eviction.
    snap();
    do_req(1'b1, 1'b0, 32'h6000, '0, '0, rd, cyc);
    check_eq("t4_no_wb", n_wr - s_wr, 0);
    check_eq("t4_fill_cnt", n_rd - s_rd, 1);
    check_eq("t4_fill_addr", last_rd_addr, 32'h6000);
    check_eq("t4_rdata", rd, fill_line(32'h6000));

    // 5: reset in the middle of a fill.
    mem_delay       = 20;
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h7000;
    for (int i = 0; i < 20 && !bus.pmem_read; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("t5_fill_started", bus.pmem_read, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_rst_pmem_read", bus.pmem_read, 0);
    check_eq("t5_rst_pmem_write", bus.pmem_write, 0);
    check_eq("t5_rst_mem_resp", bus.mem_resp, 0);
    bus.mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_delay = 2;
    snap();
    do_req(1'b1, 1'b0, 32'h5000, '0, '0, rd, cyc);
    check_eq("t5_miss_after_rst", n_rd - s_rd, 1);
    check_eq("t5_fill_addr", last_rd_addr, 32'h5000);

    // 7: read and write together act as a write (write-allocate miss).
    w         = '0;
    w[63:32]  = 32'h1234_5678;
    exp7      = fill_line(32'h1000);
    exp7[63:32] = 32'h1234_5678;
    do_req(1'b1, 1'b1, 32'h1000, w, 32'h0000_00F0, rd, cyc);
    do_req(1'b1, 1'b0, 32'h1000, '0, '0, rd, cyc);
    check_eq("t7_rw_is_write", rd, exp7);

    // 6: slow memory during write-back and fill; dirty 0x1000 (way1) is the victim.
    seq[0] = 32'h2000;
    seq[1] = 32'h3000;
    seq[2] = 32'h5000;
    seq[3] = 32'h3000;
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, seq[i], '0, '0, rd, cyc);
    mem_delay = 10;
    snap();
    do_req(1'b1, 1'b0, 32'h6000, '0, '0, rd, cyc);
    check_eq("t6_wb_cnt", n_wr - s_wr, 1);
    check_eq("t6_wb_addr", last_wr_addr, 32'h1000);
    check_eq("t6_wb_data", last_wr_data, exp7);
    check_eq("t6_fill_addr", last_rd_addr, 32'h6000);
    check_eq("t6_stable", n_unstable - s_unstable, 0);
    check_eq("t6_no_early_resp", n_resp_pmem - s_resp_pmem, 0);
    check_eq("t6_rdata", rd, fill_line(32'h6000));

    check_eq("never_rd_and_wr", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
